// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Instruction fetch front end. Issues sequential word fetches to
//            instruction memory, buffers in-order responses in a small FIFO
//            and presents the head instruction (with its PC) to decode.
//            A jump flushes the buffer, redirects fetch, and discards all
//            responses still in flight from the old stream.
// Ports    : clk, rst_n (sync, active-low)
//            jump, jump_target              - redirect from branch logic
//            imem_req_valid/addr/ready      - request channel to memory
//            imem_resp_valid/data           - in-order response channel
//            inst_valid/data/pc, inst_ready - head of buffer to decode
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int c_PW = $clog2(DEPTH);   // buffer pointer width
    localparam int c_CW = c_PW + 1;        // holds 0..DEPTH
    localparam int c_OW = c_CW + 1;        // holds count + outstanding

    logic [31:0]     r_fpc;                // next fetch address
    logic [31:0]     r_rpc;                // PC of next accepted response
    logic [c_CW-1:0] r_count;              // buffered entries
    logic [c_CW-1:0] r_out;                // requests issued, response pending
    logic [c_CW-1:0] r_drop;               // pending responses of flushed streams
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [31:0]     r_data [DEPTH];
    logic [31:0]     r_pc   [DEPTH];

    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_resp_drop;
    logic [c_OW-1:0] w_occupancy;
    logic [c_CW-1:0] w_out_next;

    // A request is only issued if its response is already guaranteed a
    // buffer slot, so the response channel never needs backpressure.
    assign w_occupancy    = {1'b0, r_count} + {1'b0, r_out};
    assign imem_req_valid = rst_n & ~jump
                          & (w_occupancy < c_OW'(DEPTH))
                          & (r_out < c_CW'(MAX_OUT));
    assign imem_req_addr  = r_fpc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_out_next  = r_out + c_CW'(w_req_fire) - c_CW'(imem_resp_valid);
    assign w_resp_drop = imem_resp_valid & (r_drop != '0);
    assign w_push      = imem_resp_valid & (r_drop == '0);

    // No bypass: a response becomes visible the cycle after it is written.
    assign inst_valid = rst_n & ~jump & (r_count != '0);
    assign inst_data  = r_data[r_rptr];
    assign inst_pc    = r_pc[r_rptr];
    assign w_pop      = inst_valid & inst_ready;

    // Control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_out <= w_out_next;
            if (jump) begin
                // Every response still owed after this edge belongs to the
                // old stream; a response landing this cycle is already
                // accounted for in w_out_next and simply dropped.
                r_fpc   <= jump_target;
                r_rpc   <= jump_target;
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_drop  <= w_out_next;
            end else begin
                if (w_req_fire) begin
                    r_fpc <= r_fpc + 32'd1;
                end
                if (w_push) begin
                    r_rpc  <= r_rpc + 32'd1;
                    r_wptr <= r_wptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PW'(1);
                end
                if (w_resp_drop) begin
                    r_drop <= r_drop - c_CW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CW'(1);
                end
            end
        end
    end

    // Buffer storage; contents are qualified by r_count so no reset needed.
    always_ff @(posedge clk) begin
        if (rst_n && !jump && w_push) begin
            r_data[r_wptr] <= imem_resp_data;
            r_pc[r_wptr]   <= r_rpc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Self-checking bench for instr_fetch_queue. An in-order memory
//            model with configurable latency feeds the DUT; a queue-based
//            reference (tagged request stream + instruction queue) predicts
//            every output each cycle. A second instance with a reset PC
//            near the top of the address space checks address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFE;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, jump, imem_req_ready, imem_resp_valid, inst_ready;
    logic [31:0] jump_target, imem_resp_data;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_req_addr, inst_data, inst_pc;

    logic        wr_req_valid, wr_inst_valid, wr_resp_valid;
    logic [31:0] wr_req_addr, wr_inst_data, wr_inst_pc, wr_resp_data;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .jump(jump), .jump_target(jump_target),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    instr_fetch_queue #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) u_wrap (
        .clk(clk), .rst_n(rst_n), .jump(1'b0), .jump_target(32'h0),
        .imem_req_valid(wr_req_valid), .imem_req_addr(wr_req_addr),
        .imem_req_ready(1'b1), .imem_resp_valid(wr_resp_valid),
        .imem_resp_data(wr_resp_data), .inst_valid(wr_inst_valid),
        .inst_data(wr_inst_data), .inst_pc(wr_inst_pc), .inst_ready(1'b1)
    );

    // ---------------- reference model state ----------------
    typedef struct { logic [31:0] addr; int epoch; } tag_t;    // issued request
    typedef struct { logic [31:0] addr; int due;   } mreq_t;   // memory pipeline
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    tag_t        oq[$];
    mreq_t       mq[$];
    ent_t        bq[$];
    logic [31:0] m_fpc = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_fixed = 1;      // 0 = random latency 1..4

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_rv, s_iv, s_wiv;
    logic [31:0] s_ra, s_pc, s_data, s_wpc, s_wdata;
    logic        wr_fire_q = 1'b0;
    logic [31:0] wr_addr_q = 32'h0;

    typedef struct {
        logic jump; logic ir;
        logic rv; logic [31:0] ra; logic iv; logic [31:0] pc;
        logic wiv; logic [31:0] wpc;
    } vec_t;
    vec_t vec[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk1(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model across the edge. Entered and left at posedge+1.
    task automatic step(input logic rn, input logic jp, input logic [31:0] tgt,
                        input logic ir, input logic rr);
        logic resp_now, e_rv, e_iv, fire, pop;
        tag_t t;
        int   lat, due;
        rst_n          = rn;
        jump           = jp;
        jump_target    = tgt;
        inst_ready     = ir;
        imem_req_ready = rr;
        resp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(mq[0].addr) : $urandom;
        wr_resp_valid   = wr_fire_q;
        wr_resp_data    = wr_addr_q;
        #4;
        s_rv = imem_req_valid;  s_ra = imem_req_addr;
        s_iv = inst_valid;      s_pc = inst_pc;      s_data = inst_data;
        s_wiv = wr_inst_valid;  s_wpc = wr_inst_pc;  s_wdata = wr_inst_data;
        wr_fire_q = rn & wr_req_valid;
        wr_addr_q = wr_req_addr;

        e_rv = rn && !jp && ((bq.size() + oq.size()) < DEPTH) && (oq.size() < MAX_OUT);
        e_iv = rn && !jp && (bq.size() > 0);
        chk1("req_valid", imem_req_valid, e_rv);
        if (rn) chk32("req_addr", imem_req_addr, m_fpc);
        chk1("inst_valid", inst_valid, e_iv);
        if (e_iv) begin
            chk32("inst_pc", inst_pc, bq[0].pc);
            chk32("inst_data", inst_data, bq[0].data);
        end

        fire = e_rv && rr;
        pop  = e_iv && ir;
        if (!rn) begin
            oq.delete(); mq.delete(); bq.delete();
            m_fpc = RESET_PC; last_due = 0; epoch++;
        end else begin
            if (resp_now) begin
                void'(mq.pop_front());
                t = oq.pop_front();
            end
            if (jp) begin
                bq.delete();
                m_fpc = tgt;
                epoch++;
            end else begin
                if (pop) void'(bq.pop_front());
                if (resp_now && t.epoch == epoch) bq.push_back('{t.addr, mem_word(t.addr)});
                if (fire) begin
                    lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                    due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    last_due = due;
                    oq.push_back('{m_fpc, epoch});
                    mq.push_back('{m_fpc, due});
                    m_fpc = m_fpc + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nreq;
        logic found;
        logic rn, jp, ir, rr;
        logic [31:0] tgt;

        //             jump  ir    rv    ra     iv    pc     wiv   wpc
        vec[0] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0000_0000};
        vec[1] = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0, 1'b0, 32'h0000_0000};
        vec[2] = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFE};
        vec[3] = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd1, 1'b1, 32'hFFFF_FFFF};
        vec[4] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2, 1'b1, 32'h0000_0000};
        vec[5] = '{1'b0, 1'b1, 1'b1, 32'd5, 1'b1, 32'd3, 1'b1, 32'h0000_0001};
        vec[6] = '{1'b0, 1'b1, 1'b1, 32'd6, 1'b1, 32'd4, 1'b1, 32'h0000_0002};
        vec[7] = '{1'b0, 1'b1, 1'b1, 32'd7, 1'b1, 32'd5, 1'b1, 32'h0000_0003};

        rst_n = 1'b0; jump = 1'b0; jump_target = 32'h0; inst_ready = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        wr_resp_valid = 1'b0; wr_resp_data = 32'h0;
        @(posedge clk);
        #1;

        // Reset state, then streaming with latency 1 (and wrap on u_wrap)
        lat_fixed = 1;
        repeat (3) step(1'b0, 1'b1, 32'h55, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vec[i].jump, 32'h0, vec[i].ir, 1'b1);
            chk1("tbl_req_valid", s_rv, vec[i].rv);
            chk32("tbl_req_addr", s_ra, vec[i].ra);
            chk1("tbl_inst_valid", s_iv, vec[i].iv);
            if (vec[i].iv) chk32("tbl_inst_pc", s_pc, vec[i].pc);
            chk1("tbl_wrap_valid", s_wiv, vec[i].wiv);
            if (vec[i].wiv) begin
                chk32("tbl_wrap_pc", s_wpc, vec[i].wpc);
                chk32("tbl_wrap_data", s_wdata, vec[i].wpc);
            end
        end

        // Backpressure: exactly DEPTH words fetched, head held, resume at 4
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            if (s_rv) nreq++;
        end
        chk32("bp_requests", 32'(nreq), 32'd4);
        chk1("bp_req_idle", s_rv, 1'b0);
        chk1("bp_head_valid", s_iv, 1'b1);
        chk32("bp_head_pc", s_pc, 32'd0);
        chk32("bp_head_data", s_data, mem_word(32'd0));
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (s_rv) begin
                found = 1'b1;
                chk32("bp_resume_addr", s_ra, 32'd4);
            end
        end
        chk1("bp_resume_seen", found, 1'b1);

        // Flush with two requests outstanding, latency 3
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lat_fixed = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (oq.size() == 2) found = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        chk1("flush_setup", found, 1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (s_iv) begin
                found = 1'b1;
                chk32("flush_first_pc", s_pc, 32'h100);
            end
        end
        chk1("flush_valid_seen", found, 1'b1);

        // Jump + response + inst_ready with the buffer as full as it can be
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bq.size() == 3 && mq.size() > 0 && mq[0].due <= cyc) found = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk1("jfull_setup", found, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk1("jfull_empty_after", s_iv, 1'b0);
        chk32("jfull_fetch_addr", s_ra, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (s_iv) begin
                found = 1'b1;
                chk32("jfull_first_pc", s_pc, 32'h200);
            end
        end
        chk1("jfull_valid_seen", found, 1'b1);

        // Reset in the middle of a stream with a full buffer
        lat_fixed = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bq.size() == DEPTH) found = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk1("rst_full_setup", found, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk1("rst_inst_valid", s_iv, 1'b0);
        chk1("rst_req_valid", s_rv, 1'b1);
        chk32("rst_req_addr", s_ra, RESET_PC);

        // Randomized traffic against the reference model
        lat_fixed = 0;
        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(0, 199) != 0);
            jp  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                              : 32'($urandom);
            ir  = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            step(rn, jp, tgt, ir, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
